instruction_fetcher: RTL and testbench

//   Per-core instruction fetch stage between the program counter and the decoder.
//   - On core FETCH, reads the instruction at current_pc from program memory using a valid/ready handshake.
//   - Holds the result stable for decode.
//   - A single-entry tagged buffer short-circuits refetch of the same PC (tight loops, branch-to-self).
//   - Saturating counters expose fetch and buffer-hit activity.

---
 rtl/instruction_fetcher.sv | 116 +++++++++++
 tb/tb_instruction_fetcher.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: valid/ready read of program memory at current_pc,
// with a single-entry tagged buffer that serves repeat fetches of the same PC.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter bit BUFFER_ENABLE         = 1'b1,
  parameter int COUNT_BITS            = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [2:0]                       i_core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] i_current_pc,
  input  logic                             i_invalidate,
  output logic                             o_mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] o_mem_read_address,
  input  logic                             i_mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] i_mem_read_data,
  output logic [2:0]                       o_fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] o_instruction,
  output logic [COUNT_BITS-1:0]            o_fetch_count,
  output logic [COUNT_BITS-1:0]            o_hit_count
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  state_t                             r_state;
  state_t                             w_next_state;
  logic                               w_fetch_req;
  logic                               w_hit;
  logic                               w_mem_done;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   w_buf_data;

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_fetch_req     = (r_state == IDLE) && (i_core_state == CORE_FETCH);
  assign w_mem_done      = (r_state == FETCHING) && i_mem_read_ready;
  assign o_fetcher_state = r_state;

  generate
    if (BUFFER_ENABLE) begin : g_buf
      logic                             r_buf_valid;
      logic [PROGRAM_MEM_ADDR_BITS-1:0] r_buf_tag;
      logic [PROGRAM_MEM_DATA_BITS-1:0] r_buf_data;

      // An invalidate in the lookup cycle must win over a matching tag.
      assign w_hit      = r_buf_valid && (r_buf_tag == i_current_pc) && !i_invalidate;
      assign w_buf_data = r_buf_data;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_buf_valid <= 1'b0;
          r_buf_tag   <= '0;
          r_buf_data  <= '0;
        end else if (i_invalidate) begin
          r_buf_valid <= 1'b0;
        end else if (w_mem_done) begin
          r_buf_valid <= 1'b1;
          r_buf_tag   <= o_mem_read_address;
          r_buf_data  <= i_mem_read_data;
        end
      end
    end else begin : g_nobuf
      assign w_hit      = 1'b0;
      assign w_buf_data = '0;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:     w_next_state = w_fetch_req ? (w_hit ? FETCHED : FETCHING) : IDLE;
      FETCHING: w_next_state = i_mem_read_ready ? FETCHED : FETCHING;
      FETCHED:  w_next_state = (i_core_state == CORE_DECODE) ? IDLE : FETCHED;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_mem_read_valid   <= 1'b0;
      o_mem_read_address <= '0;
      o_instruction      <= '0;
      o_fetch_count      <= '0;
      o_hit_count        <= '0;
    end else begin
      // Request stays up only while FETCHING awaits ready; any other state clears it.
      if (w_fetch_req && !w_hit) begin
        o_mem_read_valid   <= 1'b1;
        o_mem_read_address <= i_current_pc;
      end else if (r_state != FETCHING || i_mem_read_ready) begin
        o_mem_read_valid <= 1'b0;
      end

      if (w_fetch_req && w_hit) o_instruction <= w_buf_data;
      else if (w_mem_done)      o_instruction <= i_mem_read_data;

      if ((w_fetch_req && w_hit) || w_mem_done) o_fetch_count <= sat_inc(o_fetch_count);
      if (w_fetch_req && w_hit)                 o_hit_count   <= sat_inc(o_hit_count);
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher; a second instance with 4-bit counters
// shares all inputs so counter saturation is reachable in a short run.
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  pc;
  logic        inval;
  logic        ready;
  logic [15:0] rdata;

  logic        mvalid;
  logic [7:0]  maddr;
  logic [2:0]  fstate;
  logic [15:0] instr;
  logic [15:0] fcount;
  logic [15:0] hcount;

  logic        s_mvalid;
  logic [7:0]  s_maddr;
  logic [2:0]  s_fstate;
  logic [15:0] s_instr;
  logic [3:0]  s_fcount;
  logic [3:0]  s_hcount;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] C_NONE = 3'b000, C_FETCH = 3'b001, C_DECODE = 3'b010;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

  always #5 clk = ~clk;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16),
    .BUFFER_ENABLE(1'b1), .COUNT_BITS(16)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_core_state(core_state), .i_current_pc(pc),
    .i_invalidate(inval), .o_mem_read_valid(mvalid), .o_mem_read_address(maddr),
    .i_mem_read_ready(ready), .i_mem_read_data(rdata), .o_fetcher_state(fstate),
    .o_instruction(instr), .o_fetch_count(fcount), .o_hit_count(hcount)
  );

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16),
    .BUFFER_ENABLE(1'b1), .COUNT_BITS(4)
  ) dut_small (
    .i_clk(clk), .i_reset(reset), .i_core_state(core_state), .i_current_pc(pc),
    .i_invalidate(inval), .o_mem_read_valid(s_mvalid), .o_mem_read_address(s_maddr),
    .i_mem_read_ready(ready), .i_mem_read_data(rdata), .o_fetcher_state(s_fstate),
    .o_instruction(s_instr), .o_fetch_count(s_fcount), .o_hit_count(s_hcount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] st, input logic v,
                              input logic [15:0] ins, input logic [15:0] fc, input logic [15:0] hc);
    chk({tag, ".state"}, 32'(fstate), 32'(st));
    chk({tag, ".valid"}, 32'(mvalid), 32'(v));
    chk({tag, ".instr"}, 32'(instr), 32'(ins));
    chk({tag, ".fcount"}, 32'(fcount), 32'(fc));
    chk({tag, ".hcount"}, 32'(hcount), 32'(hc));
  endtask

  initial begin
    reset = 1'b0; core_state = C_NONE; pc = 8'h00; inval = 1'b0; ready = 1'b0; rdata = 16'h0;
    step(); step();
    expect_state("reset", S_IDLE, 1'b0, 16'h0, 16'd0, 16'd0);
    chk("reset.addr", 32'(maddr), 32'h0);
    reset = 1'b1;
    step();

    // Reset asserted mid-request must drop the request immediately.
    pc = 8'h20; core_state = C_FETCH;
    step();
    chk("rst_mid.pre_state", 32'(fstate), 32'(S_FETCHING));
    chk("rst_mid.pre_valid", 32'(mvalid), 32'h1);
    chk("rst_mid.pre_addr", 32'(maddr), 32'h20);
    core_state = C_NONE;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.valid", 32'(mvalid), 32'h0);
    chk("rst_mid.state", 32'(fstate), 32'(S_IDLE));
    #1 reset = 1'b1;
    ready = 1'b1; rdata = 16'hDEAD;
    step();
    expect_state("rst_after_ready", S_IDLE, 1'b0, 16'h0, 16'd0, 16'd0);
    ready = 1'b0;

    // Miss at pc 05, ready after three cycles of waiting.
    pc = 8'h05; core_state = C_FETCH;
    step();
    chk("miss.e1_state", 32'(fstate), 32'(S_FETCHING));
    chk("miss.e1_valid", 32'(mvalid), 32'h1);
    chk("miss.e1_addr", 32'(maddr), 32'h05);
    core_state = C_NONE;
    step();
    chk("miss.e2_addr", 32'(maddr), 32'h05);
    chk("miss.e2_valid", 32'(mvalid), 32'h1);
    step();
    chk("miss.e3_addr", 32'(maddr), 32'h05);
    chk("miss.e3_valid", 32'(mvalid), 32'h1);
    ready = 1'b1; rdata = 16'h3A21;
    step();
    expect_state("miss.done", S_FETCHED, 1'b0, 16'h3A21, 16'd1, 16'd0);
    ready = 1'b0; rdata = 16'h0;
    core_state = C_FETCH;
    step();
    expect_state("fetched.refetch", S_FETCHED, 1'b0, 16'h3A21, 16'd1, 16'd0);
    core_state = C_DECODE;
    step();
    chk("decode.state", 32'(fstate), 32'(S_IDLE));

    // Hit at pc 05: one edge, no memory request.
    core_state = C_FETCH;
    step();
    expect_state("hit", S_FETCHED, 1'b0, 16'h3A21, 16'd2, 16'd1);
    core_state = C_DECODE;
    step();

    // Invalidate pulse while idle, then fetch must miss.
    core_state = C_NONE; inval = 1'b1;
    step();
    inval = 1'b0; core_state = C_FETCH;
    step();
    chk("inv.miss_state", 32'(fstate), 32'(S_FETCHING));
    chk("inv.miss_valid", 32'(mvalid), 32'h1);
    core_state = C_NONE; ready = 1'b1; rdata = 16'h1111; inval = 1'b1;
    step();
    expect_state("inv.with_ready", S_FETCHED, 1'b0, 16'h1111, 16'd3, 16'd1);
    ready = 1'b0; inval = 1'b0; core_state = C_DECODE;
    step();
    core_state = C_FETCH;
    step();
    chk("inv.no_load_state", 32'(fstate), 32'(S_FETCHING));
    chk("inv.no_load_valid", 32'(mvalid), 32'h1);
    ready = 1'b1; rdata = 16'h1111; core_state = C_NONE;
    step();
    ready = 1'b0; core_state = C_DECODE;
    step();
    // Buffer now valid for 05; invalidate on the lookup cycle still forces a miss.
    core_state = C_FETCH; inval = 1'b1;
    step();
    chk("inv.lookup_state", 32'(fstate), 32'(S_FETCHING));
    chk("inv.lookup_valid", 32'(mvalid), 32'h1);
    chk("inv.lookup_hcount", 32'(hcount), 32'd1);
    inval = 1'b0; core_state = C_NONE; ready = 1'b1; rdata = 16'h2222;
    step();
    expect_state("inv.lookup_done", S_FETCHED, 1'b0, 16'h2222, 16'd5, 16'd1);
    ready = 1'b0; core_state = C_DECODE;
    step();

    // PC changes during FETCHING are ignored; ready while idle is ignored.
    pc = 8'h10; core_state = C_FETCH;
    step();
    chk("stab.addr1", 32'(maddr), 32'h10);
    pc = 8'h11; core_state = C_NONE;
    step();
    chk("stab.addr2", 32'(maddr), 32'h10);
    chk("stab.valid2", 32'(mvalid), 32'h1);
    ready = 1'b1; rdata = 16'h4B4B;
    step();
    expect_state("stab.done", S_FETCHED, 1'b0, 16'h4B4B, 16'd6, 16'd1);
    ready = 1'b0; core_state = C_DECODE;
    step();
    core_state = C_NONE; ready = 1'b1; rdata = 16'hFFFF;
    step();
    expect_state("stab.idle_ready", S_IDLE, 1'b0, 16'h4B4B, 16'd6, 16'd1);
    ready = 1'b0;

    // Repeated hits at pc 10 drive the 4-bit counters into saturation.
    pc = 8'h10;
    for (int i = 0; i < 8; i++) begin
      core_state = C_FETCH;  step();
      core_state = C_DECODE; step();
    end
    chk("sat.pre_small_fc", 32'(s_fcount), 32'hE);
    chk("sat.pre_fc", 32'(fcount), 32'd14);
    for (int i = 0; i < 3; i++) begin
      core_state = C_FETCH;  step();
      core_state = C_DECODE; step();
    end
    chk("sat.small_fc", 32'(s_fcount), 32'hF);
    chk("sat.fc", 32'(fcount), 32'd17);
    chk("sat.small_hc_pre", 32'(s_hcount), 32'hC);
    for (int i = 0; i < 4; i++) begin
      core_state = C_FETCH;  step();
      core_state = C_DECODE; step();
    end
    chk("sat.small_fc_hold", 32'(s_fcount), 32'hF);
    chk("sat.small_hc", 32'(s_hcount), 32'hF);
    chk("sat.hc", 32'(hcount), 32'd16);
    chk("sat.fc_end", 32'(fcount), 32'd21);
    chk("sat.small_instr", 32'(s_instr), 32'h4B4B);
    chk("sat.small_state", 32'(s_fstate), 32'(S_IDLE));
    chk("sat.small_valid", 32'(s_mvalid), 32'h0);
    chk("sat.small_addr", 32'(s_maddr), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
